firc_stream_tx: RTL and testbench

//  Transmit-side driver for the firc filter's push/stop and coefficient-load interfaces.
//  A host writes samples into an internal sample FIFO, and coefficients into a shadow table.
//  The block streams samples to firc using PushIn/SampI/SampQ, and honours firc's StopIn.
//  On command, it bursts the shadow table to firc using PushCoef/CoefAddr/CoefI/CoefQ.

---
 rtl/fir_structs_pkg.sv | 29 ++
 rtl/firc_tx_fifo.sv | 69 ++++++
 rtl/firc_stream_tx.sv | 169 ++++++++++++++++
 tb/tb_firc_stream_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_structs_pkg.sv
// Shared types and sizes for the firc transmit-side driver.
package fir_structs;

    localparam int unsigned SAMP_W        = 24;
    localparam int unsigned COEF_W        = 27;
    localparam int unsigned NUM_COEF      = 15;
    localparam int unsigned TX_FIFO_DEPTH = 8;
    localparam int unsigned HADDR_W       = 4;
    localparam int unsigned CADDR_W       = 5;

    // One complex sample, I rail in the upper half
    typedef struct packed {
        logic [SAMP_W-1:0] i;
        logic [SAMP_W-1:0] q;
    } samp_t;

    // One complex coefficient, I rail in the upper half
    typedef struct packed {
        logic [COEF_W-1:0] i;
        logic [COEF_W-1:0] q;
    } coef_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_LOAD   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/firc_tx_fifo.sv
// First-word fall-through FIFO; the head entry is visible on o_dout straight from storage.
module firc_tx_fifo #(
    parameter int unsigned W     = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_wr;
    logic          w_rd;
    logic [CW-1:0] w_count_next;

    // A push while full is dropped even when a pop happens in the same cycle
    assign w_wr         = i_push & ~r_full;
    assign w_rd         = i_pop & ~r_empty;
    assign w_count_next = r_count + CW'(w_wr) - CW'(w_rd);

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

    // Storage write; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; flags follow the next count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

endmodule

// File: rtl/firc_stream_tx.sv
// Transmit driver for firc: streams buffered samples and bursts the shadow coefficient table.
module firc_stream_tx
    import fir_structs::*;
#(
    parameter int unsigned FIFO_DEPTH = TX_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               HostPushSamp,
    input  logic [SAMP_W-1:0]  HostSampI,
    input  logic [SAMP_W-1:0]  HostSampQ,
    output logic               HostStop,
    input  logic               HostCoefWe,
    input  logic [HADDR_W-1:0] HostCoefAddr,
    input  logic [COEF_W-1:0]  HostCoefI,
    input  logic [COEF_W-1:0]  HostCoefQ,
    input  logic               LoadCoef,
    output logic               CoefBusy,
    output logic               PushIn,
    input  logic               StopIn,
    output logic [SAMP_W-1:0]  SampI,
    output logic [SAMP_W-1:0]  SampQ,
    output logic               PushCoef,
    output logic [CADDR_W-1:0] CoefAddr,
    output logic [COEF_W-1:0]  CoefI,
    output logic [COEF_W-1:0]  CoefQ
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e          r_state;
    tx_state_e          w_state_next;
    logic               r_pending;
    coef_t              r_shadow [NUM_COEF];
    logic [HADDR_W-1:0] r_cidx;
    logic               r_push_coef;
    logic [CADDR_W-1:0] r_coef_addr;
    coef_t              r_coef;

    samp_t              w_head;
    samp_t              w_din;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic               w_push_acc;
    logic               w_pop;
    logic               w_nonempty_next;
    logic               w_busy;
    logic               w_last;
    logic               w_enter_load;
    logic [HADDR_W-1:0] w_cidx_next;

    assign w_din      = '{i: HostSampI, q: HostSampQ};
    assign w_push_acc = HostPushSamp & ~w_full;
    assign w_pop      = (r_state == S_STREAM) & ~w_empty & ~StopIn;
    assign w_busy     = r_pending | (r_state == S_LOAD);
    assign w_last     = (r_cidx == HADDR_W'(NUM_COEF - 1));

    // Occupancy after this edge, so a fresh push reaches firc one cycle later
    assign w_nonempty_next = (w_count > CW'(1)) | ((w_count == CW'(1)) & ~w_pop) | w_push_acc;

    assign PushIn   = w_pop;
    assign SampI    = w_head.i;
    assign SampQ    = w_head.q;
    assign HostStop = w_full;
    assign CoefBusy = w_busy;
    assign PushCoef = r_push_coef;
    assign CoefAddr = r_coef_addr;
    assign CoefI    = r_coef.i;
    assign CoefQ    = r_coef.q;

    firc_tx_fifo #(
        .W     ($bits(samp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (Reset),
        .i_push  (HostPushSamp),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a pending load preempts streaming; a burst always runs to its last address
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_STREAM: begin
                if (r_pending) begin
                    w_state_next = S_LOAD;
                end else if (w_nonempty_next) begin
                    w_state_next = S_STREAM;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_LOAD: begin
                if (!w_last || r_pending) begin
                    w_state_next = S_LOAD;
                end else if (w_nonempty_next) begin
                    w_state_next = S_STREAM;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode: burst start detection and the coefficient index for the next cycle
    always_comb begin
        w_enter_load = 1'b0;
        w_cidx_next  = r_cidx;
        if (w_state_next == S_LOAD) begin
            w_enter_load = (r_state != S_LOAD) | w_last;
            w_cidx_next  = w_enter_load ? '0 : r_cidx + HADDR_W'(1);
        end
    end

    // Load request flag; a new request on the entry edge is kept so it is not lost
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= LoadCoef | (r_pending & ~w_enter_load);
        end
    end

    // Shadow table; host writes are locked out while a load is pending or running
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < int'(NUM_COEF); k++) begin
                r_shadow[k] <= '0;
            end
        end else if (HostCoefWe && !w_busy && (HostCoefAddr < HADDR_W'(NUM_COEF))) begin
            r_shadow[HostCoefAddr] <= '{i: HostCoefI, q: HostCoefQ};
        end
    end

    // Registered coefficient burst; address and data hold their last values between bursts
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cidx      <= '0;
            r_push_coef <= 1'b0;
            r_coef_addr <= '0;
            r_coef      <= '0;
        end else if (w_state_next == S_LOAD) begin
            r_cidx      <= w_cidx_next;
            r_push_coef <= 1'b1;
            r_coef_addr <= CADDR_W'(w_cidx_next);
            r_coef      <= r_shadow[w_cidx_next];
        end else begin
            r_push_coef <= 1'b0;
        end
    end

endmodule

// File: tb/tb_firc_stream_tx.sv
// Self-checking bench for firc_stream_tx against a queue-based transaction model.
module tb_firc_stream_tx;

    localparam int SW = 24;
    localparam int CWD = 27;
    localparam int NC = 15;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            Reset;
    logic            HostPushSamp;
    logic [SW-1:0]   HostSampI;
    logic [SW-1:0]   HostSampQ;
    logic            HostStop;
    logic            HostCoefWe;
    logic [3:0]      HostCoefAddr;
    logic [CWD-1:0]  HostCoefI;
    logic [CWD-1:0]  HostCoefQ;
    logic            LoadCoef;
    logic            CoefBusy;
    logic            PushIn;
    logic            StopIn;
    logic [SW-1:0]   SampI;
    logic [SW-1:0]   SampQ;
    logic            PushCoef;
    logic [4:0]      CoefAddr;
    logic [CWD-1:0]  CoefI;
    logic [CWD-1:0]  CoefQ;

    firc_stream_tx dut (
        .clk          (clk),
        .Reset        (Reset),
        .HostPushSamp (HostPushSamp),
        .HostSampI    (HostSampI),
        .HostSampQ    (HostSampQ),
        .HostStop     (HostStop),
        .HostCoefWe   (HostCoefWe),
        .HostCoefAddr (HostCoefAddr),
        .HostCoefI    (HostCoefI),
        .HostCoefQ    (HostCoefQ),
        .LoadCoef     (LoadCoef),
        .CoefBusy     (CoefBusy),
        .PushIn       (PushIn),
        .StopIn       (StopIn),
        .SampI        (SampI),
        .SampQ        (SampQ),
        .PushCoef     (PushCoef),
        .CoefAddr     (CoefAddr),
        .CoefI        (CoefI),
        .CoefQ        (CoefQ)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: sample queue, shadow table, activity mode, burst index
    logic [2*SW-1:0]  mq[$];
    logic [2*CWD-1:0] msh [NC];
    int               mmode;   // 0 idle, 1 streaming, 2 loading
    int               midx;
    bit               mpend;
    bit               mpc;
    logic [4:0]       mca;
    logic [CWD-1:0]   mci;
    logic [CWD-1:0]   mcq;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < NC; k++) msh[k] = '0;
        mmode = 0;
        midx  = 0;
        mpend = 0;
        mpc   = 0;
        mca   = '0;
        mci   = '0;
        mcq   = '0;
    endtask

    // Advance the model by one clock edge using the inputs held during the cycle
    task automatic model_step();
        bit pop, busy, acc, took;
        pop  = (mmode == 1) && (mq.size() > 0) && !StopIn;
        busy = mpend || (mmode == 2);
        acc  = HostPushSamp && (mq.size() < DEPTH);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({HostSampI, HostSampQ});
        took = 0;
        if (mmode == 2 && midx < NC - 1) begin
            midx++;
        end else if (mpend) begin
            mmode = 2;
            midx  = 0;
            took  = 1;
        end else begin
            mmode = (mq.size() > 0) ? 1 : 0;
        end
        mpend = LoadCoef || (mpend && !took);
        if (HostCoefWe && HostCoefAddr < NC && !busy) msh[HostCoefAddr] = {HostCoefI, HostCoefQ};
        if (mmode == 2) begin
            mpc = 1;
            mca = 5'(midx);
            {mci, mcq} = msh[midx];
        end else begin
            mpc = 0;
        end
    endtask

    task automatic check_outputs();
        logic [2*SW-1:0] head;
        check_val("PushIn", PushIn, (mmode == 1) && (mq.size() > 0) && !StopIn);
        if (mq.size() > 0) begin
            head = mq[0];
            check_val("SampI", SampI, head[2*SW-1:SW]);
            check_val("SampQ", SampQ, head[SW-1:0]);
        end
        check_val("HostStop", HostStop, mq.size() == DEPTH);
        check_val("CoefBusy", CoefBusy, mpend || (mmode == 2));
        check_val("PushCoef", PushCoef, mpc);
        check_val("CoefAddr", CoefAddr, mca);
        check_val("CoefI", CoefI, mci);
        check_val("CoefQ", CoefQ, mcq);
    endtask

    task automatic clear_strobes();
        HostPushSamp = 0;
        HostCoefWe   = 0;
        LoadCoef     = 0;
    endtask

    // One clock: check mid-cycle, step the model on the edge, return just after it
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        clear_strobes();
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Async reset: all listed outputs must drop before any clock edge
    task automatic apply_reset();
        clear_strobes();
        Reset = 1;
        #1;
        check_val("rst_PushIn", PushIn, 0);
        check_val("rst_PushCoef", PushCoef, 0);
        check_val("rst_CoefAddr", CoefAddr, 0);
        check_val("rst_CoefI", CoefI, 0);
        check_val("rst_CoefQ", CoefQ, 0);
        check_val("rst_HostStop", HostStop, 0);
        check_val("rst_CoefBusy", CoefBusy, 0);
        model_reset();
        @(negedge clk);
        Reset = 0;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic push_samp(input logic [SW-1:0] si, input logic [SW-1:0] sq);
        HostPushSamp = 1;
        HostSampI    = si;
        HostSampQ    = sq;
        cycle();
        HostPushSamp = 0;
    endtask

    initial begin
        Reset = 0;
        StopIn = 0;
        HostSampI = '0;
        HostSampQ = '0;
        HostCoefAddr = '0;
        HostCoefI = '0;
        HostCoefQ = '0;
        clear_strobes();
        apply_reset();
        idle(3);

        // Shadow k = k+1 / -(k+1), then one burst
        for (int k = 0; k < NC; k++) begin
            HostCoefWe   = 1;
            HostCoefAddr = 4'(k);
            HostCoefI    = CWD'(k + 1);
            HostCoefQ    = CWD'(-(k + 1));
            cycle();
        end
        clear_strobes();
        LoadCoef = 1;
        cycle();
        idle(20);

        // Three back-to-back samples
        for (int k = 1; k <= 3; k++) push_samp(SW'(k), SW'(-k));
        idle(6);

        // Fill under backpressure; ninth push dropped
        StopIn = 1;
        for (int k = 1; k <= 9; k++) push_samp(SW'(16 + k), SW'(-(16 + k)));
        idle(3);
        StopIn = 0;
        idle(12);

        // Load request arriving with the first pop of a four-deep queue
        StopIn = 1;
        for (int k = 1; k <= 4; k++) push_samp(SW'(32 + k), SW'(-(32 + k)));
        StopIn = 0;
        LoadCoef = 1;
        cycle();
        idle(25);

        // Re-request mid-burst with a locked-out shadow write, then reset in the second burst
        LoadCoef = 1;
        cycle();
        clear_strobes();
        begin
            int t;
            for (t = 0; t < 40 && !(mpc && mca == 5'd7); t++) cycle();
            check_val("t6_reach_addr7", (t < 40), 1);
        end
        LoadCoef     = 1;
        HostCoefWe   = 1;
        HostCoefAddr = 4'd0;
        HostCoefI    = CWD'(27'h123456);
        HostCoefQ    = CWD'(27'h654321);
        cycle();
        idle(12);
        apply_reset();
        idle(20);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 4000; n++) begin
            HostPushSamp = ($urandom_range(0, 99) < 50);
            HostSampI    = SW'($urandom);
            HostSampQ    = SW'($urandom);
            StopIn       = ($urandom_range(0, 99) < 30);
            HostCoefWe   = ($urandom_range(0, 99) < 20);
            HostCoefAddr = 4'($urandom_range(0, 15));
            HostCoefI    = CWD'($urandom);
            HostCoefQ    = CWD'($urandom);
            LoadCoef     = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 3) apply_reset();
            else cycle();
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
